// File: rtl/bipolar_3_level_pkg.sv
// ============================================================================
// Module : bipolar_3_level_pkg
// Brief  : Line levels, mark polarities and the code-rule helper shared by
//          the bipolar 3-level encoder and decoder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package bipolar_3_level_pkg;

    localparam logic MARK_LEVEL  = 1'b0;
    localparam logic SPACE_LEVEL = 1'b1;
    localparam logic POS_SIGN    = 1'b1;
    localparam logic NEG_SIGN    = 1'b0;

    // A run opens with a positive mark; every later mark in the run alternates.
    function automatic logic mark_breaks_rule(input logic in_run,
                                              input logic prev_sign,
                                              input logic sign);
        return in_run ? (sign == prev_sign) : (sign != POS_SIGN);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bipolar_3_level_decode_if.sv
// ============================================================================
// Module : bipolar_3_level_decode_if
// Brief  : Line inputs and decoded outputs of the bipolar 3-level decoder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface bipolar_3_level_decode_if #(
    parameter int WORD_W = 8,
    parameter int ERR_W  = 16
);
    logic              ENCODED;
    logic              SIGN;
    logic              CLR_ERR;
    logic              DATA;
    logic              VIOLATION;
    logic [WORD_W-1:0] DATA_WORD;
    logic              WORD_VALID;
    logic              WORD_ERR;
    logic [ERR_W-1:0]  ERR_COUNT;
    logic              LOS;

    modport master (
        output ENCODED, SIGN, CLR_ERR,
        input  DATA, VIOLATION, DATA_WORD, WORD_VALID, WORD_ERR, ERR_COUNT, LOS
    );

    modport slave (
        input  ENCODED, SIGN, CLR_ERR,
        output DATA, VIOLATION, DATA_WORD, WORD_VALID, WORD_ERR, ERR_COUNT, LOS
    );
endinterface

`default_nettype wire

// File: rtl/bipolar_3_level_deser.sv
// ============================================================================
// Module : bipolar_3_level_deser
// Brief  : MSB-first word assembly with a per-word violation flag.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bipolar_3_level_deser #(
    parameter int WORD_W = 8
) (
    input  wire logic              CLK,
    input  wire logic              CPU_RESET,
    input  wire logic              i_bit,
    input  wire logic              i_viol,
    output logic      [WORD_W-1:0] o_word,
    output logic                   o_word_valid,
    output logic                   o_word_err
);
    localparam int CNT_W = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [WORD_W-1:0] shift_q,   shift_d;
    logic              err_acc_q, err_acc_d;
    logic [WORD_W-1:0] word_q,    word_d;
    logic              valid_q,   valid_d;
    logic              werr_q,    werr_d;

    logic [WORD_W-1:0] w_shift;
    logic              w_err;

    // Inputs are the values being registered onto DATA/VIOLATION this edge,
    // so the word completes on the same cycle its last bit shows on DATA.
    always_comb begin
        w_shift   = {shift_q[WORD_W-2:0], i_bit};
        w_err     = err_acc_q | i_viol;
        cnt_d     = cnt_q + CNT_W'(1);
        shift_d   = w_shift;
        err_acc_d = w_err;
        word_d    = word_q;
        valid_d   = 1'b0;
        werr_d    = 1'b0;
        if (cnt_q == LAST_BIT) begin
            cnt_d     = '0;
            shift_d   = '0;
            err_acc_d = 1'b0;
            word_d    = w_shift;
            valid_d   = 1'b1;
            werr_d    = w_err;
        end
    end

    always_ff @(posedge CLK or posedge CPU_RESET) begin
        if (CPU_RESET) begin
            cnt_q     <= '0;
            shift_q   <= '0;
            err_acc_q <= 1'b0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            werr_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            err_acc_q <= err_acc_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            werr_q    <= werr_d;
        end
    end

    assign o_word       = word_q;
    assign o_word_valid = valid_q;
    assign o_word_err   = werr_q;

endmodule

`default_nettype wire

// File: rtl/bipolar_3_level_decode.sv
// ============================================================================
// Module : bipolar_3_level_decode
// Brief  : Bipolar 3-level line decoder: bit recovery, code-rule checking,
//          violation counting, loss-of-signal and word assembly.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bipolar_3_level_decode
    import bipolar_3_level_pkg::*;
#(
    parameter int WORD_W    = 8,
    parameter int LOS_LIMIT = 32,
    parameter int ERR_W     = 16
) (
    input  wire logic                 CLK,
    input  wire logic                 CPU_RESET,
    bipolar_3_level_decode_if.slave   bus
);
    localparam int RUN_W = $clog2(LOS_LIMIT + 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOS_LIMIT);

    logic             data_q,      data_d;
    logic             violation_q, violation_d;
    logic             prev_mark_q, prev_mark_d;
    logic             prev_sign_q, prev_sign_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic [RUN_W-1:0] run_cnt_q,   run_cnt_d;
    logic             los_q,       los_d;

    logic              w_mark;
    logic [WORD_W-1:0] w_word;
    logic              w_word_valid;
    logic              w_word_err;

    always_comb begin
        w_mark      = (bus.ENCODED == MARK_LEVEL);
        data_d      = w_mark;
        violation_d = w_mark && mark_breaks_rule(prev_mark_q, prev_sign_q, bus.SIGN);
        prev_mark_d = w_mark;
        prev_sign_d = w_mark ? bus.SIGN : NEG_SIGN;

        // A clear coinciding with a violation keeps that violation counted.
        err_count_d = err_count_q;
        if (bus.CLR_ERR) begin
            err_count_d = ERR_W'(violation_d);
        end else if (violation_d && (err_count_q != ERR_MAX)) begin
            err_count_d = err_count_q + ERR_W'(1);
        end

        run_cnt_d = run_cnt_q;
        if (w_mark) begin
            run_cnt_d = '0;
        end else if (run_cnt_q != RUN_MAX) begin
            run_cnt_d = run_cnt_q + RUN_W'(1);
        end
        los_d = !w_mark && (run_cnt_d == RUN_MAX);
    end

    always_ff @(posedge CLK or posedge CPU_RESET) begin
        if (CPU_RESET) begin
            data_q      <= 1'b0;
            violation_q <= 1'b0;
            prev_mark_q <= 1'b0;
            prev_sign_q <= 1'b0;
            err_count_q <= '0;
            run_cnt_q   <= '0;
            los_q       <= 1'b0;
        end else begin
            data_q      <= data_d;
            violation_q <= violation_d;
            prev_mark_q <= prev_mark_d;
            prev_sign_q <= prev_sign_d;
            err_count_q <= err_count_d;
            run_cnt_q   <= run_cnt_d;
            los_q       <= los_d;
        end
    end

    bipolar_3_level_deser #(
        .WORD_W (WORD_W)
    ) u_deser (
        .CLK          (CLK),
        .CPU_RESET    (CPU_RESET),
        .i_bit        (data_d),
        .i_viol       (violation_d),
        .o_word       (w_word),
        .o_word_valid (w_word_valid),
        .o_word_err   (w_word_err)
    );

    assign bus.DATA       = data_q;
    assign bus.VIOLATION  = violation_q;
    assign bus.DATA_WORD  = w_word;
    assign bus.WORD_VALID = w_word_valid;
    assign bus.WORD_ERR   = w_word_err;
    assign bus.ERR_COUNT  = err_count_q;
    assign bus.LOS        = los_q;

endmodule

`default_nettype wire
